// File: rtl/mult_err_accum.sv
// Error-metric accumulator for 8x8 approximate multipliers: streams (a, b, r_approx),
// compares against the exact product and keeps error count, saturating sum and max error distance.
module mult_err_accum #(
   parameter int N_SAMPLES = 65536,
   parameter int SUM_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   input  logic [15:0]      r_approx,
   output logic             busy,
   output logic             done,
   output logic [16:0]      sample_count,
   output logic [16:0]      err_count,
   output logic [SUM_W-1:0] sum_ed,
   output logic [15:0]      max_ed
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [16:0] LAST = 17'(N_SAMPLES - 1);

   state_t            state, state_nxt;
   logic [16:0]       acc_cnt;
   logic              accept, last_acc, go;
   logic [1:0]        vld_pipe;   // [0] = stage 1 (product), [1] = stage 2 (error distance)
   logic [15:0]       exact_q, r_q, ed, ed_q;
   logic [SUM_W:0]    sum_wide;

   assign accept   = in_valid && in_ready;
   assign last_acc = accept && (acc_cnt == LAST);
   assign go       = start && (state == IDLE || state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go) state_nxt = RUN;
         RUN:     if (last_acc) state_nxt = DRAIN;
         DRAIN:   if (vld_pipe == 2'b00) state_nxt = DONE;
         DONE:    if (go) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state == RUN);
      busy     = (state == RUN) || (state == DRAIN);
      done     = (state == DONE);
   end

   assign ed       = (exact_q >= r_q) ? (exact_q - r_q) : (r_q - exact_q);
   assign sum_wide = {1'b0, sum_ed} + (SUM_W+1)'(ed_q);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe <= 2'b00;
         exact_q  <= '0;
         r_q      <= '0;
         ed_q     <= '0;
      end else begin
         vld_pipe <= {vld_pipe[0], accept};
         if (accept) begin
            exact_q <= 16'(a) * 16'(b);
            r_q     <= r_approx;
         end
         if (vld_pipe[0]) ed_q <= ed;
      end
   end

   // Start only arrives with an empty pipeline, so clearing cannot collide with an update.
   always_ff @(posedge clk) begin
      if (!rst_n || go) begin
         acc_cnt      <= '0;
         sample_count <= '0;
         err_count    <= '0;
         sum_ed       <= '0;
         max_ed       <= '0;
      end else begin
         if (accept) acc_cnt <= acc_cnt + 17'd1;
         if (vld_pipe[1]) begin
            sample_count <= sample_count + 17'd1;
            err_count    <= err_count + 17'(ed_q != 16'd0);
            sum_ed       <= sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
            if (ed_q > max_ed) max_ed <= ed_q;
         end
      end
   end

endmodule

// File: tb/tb_mult_err_accum.sv
// Directed bench for mult_err_accum: four instances with different run lengths and
// accumulator widths share the sample bus; each has its own start.
module tb_mult_err_accum;

   logic clk = 1'b0;
   logic rst_n, in_valid;
   logic [7:0] a, b;
   logic [15:0] r_approx;
   logic start4, start3, start1, starts;

   logic rdy4, busy4, done4; logic [16:0] cnt4, err4; logic [31:0] sum4; logic [15:0] max4;
   logic rdy3, busy3, done3; logic [16:0] cnt3, err3; logic [31:0] sum3; logic [15:0] max3;
   logic rdy1, busy1, done1; logic [16:0] cnt1, err1; logic [31:0] sum1; logic [15:0] max1;
   logic rdys, busys, dones; logic [16:0] cnts, errs; logic [23:0] sums; logic [15:0] maxs;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mult_err_accum #(.N_SAMPLES(4), .SUM_W(32)) u4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid), .in_ready(rdy4),
      .a(a), .b(b), .r_approx(r_approx), .busy(busy4), .done(done4),
      .sample_count(cnt4), .err_count(err4), .sum_ed(sum4), .max_ed(max4));

   mult_err_accum #(.N_SAMPLES(3), .SUM_W(32)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .in_valid(in_valid), .in_ready(rdy3),
      .a(a), .b(b), .r_approx(r_approx), .busy(busy3), .done(done3),
      .sample_count(cnt3), .err_count(err3), .sum_ed(sum3), .max_ed(max3));

   mult_err_accum #(.N_SAMPLES(1), .SUM_W(32)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid), .in_ready(rdy1),
      .a(a), .b(b), .r_approx(r_approx), .busy(busy1), .done(done1),
      .sample_count(cnt1), .err_count(err1), .sum_ed(sum1), .max_ed(max1));

   mult_err_accum #(.N_SAMPLES(300), .SUM_W(24)) us (
      .clk(clk), .rst_n(rst_n), .start(starts), .in_valid(in_valid), .in_ready(rdys),
      .a(a), .b(b), .r_approx(r_approx), .busy(busys), .done(dones),
      .sample_count(cnts), .err_count(errs), .sum_ed(sums), .max_ed(maxs));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [7:0] fa, input logic [7:0] fb, input logic [15:0] fr);
      in_valid = 1'b1; a = fa; b = fb; r_approx = fr;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; r_approx = '0;
      start4 = 1'b0; start3 = 1'b0; start1 = 1'b0; starts = 1'b0;
      tick(); tick();
      checks++; if ({rdy4, busy4, done4} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b expected 000", {rdy4, busy4, done4}); end
      checks++; if (cnt4 !== 17'd0 || err4 !== 17'd0) begin errors++; $display("FAIL reset_counts: got cnt=%0d err=%0d expected 0", cnt4, err4); end
      checks++; if (sum4 !== 32'd0 || max4 !== 16'd0) begin errors++; $display("FAIL reset_ed: got sum=%0d max=%0d expected 0", sum4, max4); end
      checks++; if ({rdy3, rdy1, rdys, done3, done1, dones} !== 6'b0) begin errors++; $display("FAIL reset_others: got %b expected 0", {rdy3, rdy1, rdys, done3, done1, dones}); end
      rst_n = 1'b1;
      in_valid = 1'b1; a = 8'd3; b = 8'd5; r_approx = 16'd0;
      repeat (4) tick();
      in_valid = 1'b0;
      checks++; if (cnt4 !== 17'd0 || rdy4 !== 1'b0) begin errors++; $display("FAIL idle_ignore: got cnt=%0d rdy=%b expected 0 0", cnt4, rdy4); end
   endtask

   task automatic test_exact();
      int n;
      start4 = 1'b1; tick(); start4 = 1'b0;
      checks++; if (rdy4 !== 1'b1 || busy4 !== 1'b1) begin errors++; $display("FAIL exact_run: got rdy=%b busy=%b expected 1 1", rdy4, busy4); end
      feed(8'd3, 8'd5, 16'd15);
      feed(8'd255, 8'd255, 16'd65025);
      feed(8'd0, 8'd9, 16'd0);
      feed(8'd16, 8'd16, 16'd256);
      in_valid = 1'b0;
      checks++; if (rdy4 !== 1'b0 || busy4 !== 1'b1) begin errors++; $display("FAIL exact_drain: got rdy=%b busy=%b expected 0 1", rdy4, busy4); end
      n = 0;
      while (done4 !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (n !== 3) begin errors++; $display("FAIL exact_done_latency: got %0d cycles expected 3", n); end
      checks++; if (cnt4 !== 17'd4 || err4 !== 17'd0) begin errors++; $display("FAIL exact_counts: got cnt=%0d err=%0d expected 4 0", cnt4, err4); end
      checks++; if (sum4 !== 32'd0 || max4 !== 16'd0) begin errors++; $display("FAIL exact_ed: got sum=%0d max=%0d expected 0 0", sum4, max4); end
   endtask

   task automatic test_error();
      int n;
      logic [7:0]  ea [3] = '{8'd10, 8'd7, 8'd2};
      logic [7:0]  eb [3] = '{8'd10, 8'd8, 8'd2};
      logic [15:0] er [3] = '{16'd96, 16'd60, 16'd4};
      logic [16:0] lat_exp [3] = '{17'd0, 17'd0, 17'd1};
      start3 = 1'b1; tick(); start3 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         feed(ea[i], eb[i], er[i]);
         checks++; if (cnt3 !== lat_exp[i]) begin errors++; $display("FAIL err_latency%0d: got %0d expected %0d", i, cnt3, lat_exp[i]); end
      end
      in_valid = 1'b0;
      n = 0;
      while (done3 !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (cnt3 !== 17'd3 || err3 !== 17'd2) begin errors++; $display("FAIL err_counts: got cnt=%0d err=%0d expected 3 2", cnt3, err3); end
      checks++; if (sum3 !== 32'd8 || max3 !== 16'd4) begin errors++; $display("FAIL err_ed: got sum=%0d max=%0d expected 8 4", sum3, max3); end

      start1 = 1'b1; tick(); start1 = 1'b0;
      feed(8'd200, 8'd200, 16'd0);
      in_valid = 1'b0;
      n = 0;
      while (done1 !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (n !== 3 || cnt1 !== 17'd1 || err1 !== 17'd1) begin errors++; $display("FAIL single_counts: got lat=%0d cnt=%0d err=%0d expected 3 1 1", n, cnt1, err1); end
      checks++; if (max1 !== 16'd40000 || sum1 !== 32'd40000) begin errors++; $display("FAIL single_ed: got max=%0d sum=%0d expected 40000 40000", max1, sum1); end
   endtask

   task automatic test_throttle();
      int idx, acc, c;
      logic [7:0]  ea [3] = '{8'd10, 8'd7, 8'd2};
      logic [7:0]  eb [3] = '{8'd10, 8'd8, 8'd2};
      logic [15:0] er [3] = '{16'd96, 16'd60, 16'd4};
      start3 = 1'b1; tick(); start3 = 1'b0;
      checks++; if (cnt3 !== 17'd0 || sum3 !== 32'd0 || max3 !== 16'd0) begin errors++; $display("FAIL restart_clear: got cnt=%0d sum=%0d max=%0d expected 0", cnt3, sum3, max3); end
      idx = 0; acc = 0; c = 0;
      while (done3 !== 1'b1 && c < 40) begin
         if (idx >= 3) begin
            in_valid = 1'b1; a = 8'd1; b = 8'd1; r_approx = 16'd99;
         end else begin
            in_valid = (c % 2 == 0); a = ea[idx]; b = eb[idx]; r_approx = er[idx];
         end
         if (in_valid && rdy3) begin acc++; idx++; end
         tick();
         c++;
      end
      in_valid = 1'b0;
      checks++; if (acc !== 3 || done3 !== 1'b1) begin errors++; $display("FAIL thr_accepts: got %0d done=%b expected 3 1", acc, done3); end
      checks++; if (cnt3 !== 17'd3 || err3 !== 17'd2) begin errors++; $display("FAIL thr_counts: got cnt=%0d err=%0d expected 3 2", cnt3, err3); end
      checks++; if (sum3 !== 32'd8 || max3 !== 16'd4) begin errors++; $display("FAIL thr_ed: got sum=%0d max=%0d expected 8 4", sum3, max3); end
   endtask

   task automatic test_saturation();
      int n;
      starts = 1'b1; tick(); starts = 1'b0;
      in_valid = 1'b1; a = 8'd255; b = 8'd255; r_approx = 16'd0;
      n = 0;
      while (dones !== 1'b1 && n < 400) begin tick(); n++; end
      in_valid = 1'b0;
      checks++; if (n !== 303) begin errors++; $display("FAIL sat_latency: got %0d cycles expected 303", n); end
      checks++; if (sums !== 24'd16777215) begin errors++; $display("FAIL sat_sum: got %0d expected 16777215", sums); end
      checks++; if (errs !== 17'd300 || cnts !== 17'd300 || maxs !== 16'd65025) begin errors++; $display("FAIL sat_counts: got err=%0d cnt=%0d max=%0d expected 300 300 65025", errs, cnts, maxs); end
   endtask

   task automatic test_control();
      int n;
      start4 = 1'b1; tick(); start4 = 1'b0;
      checks++; if (cnt4 !== 17'd0 || done4 !== 1'b0 || busy4 !== 1'b1) begin errors++; $display("FAIL done_restart: got cnt=%0d done=%b busy=%b expected 0 0 1", cnt4, done4, busy4); end
      feed(8'd10, 8'd10, 16'd96);
      feed(8'd10, 8'd10, 16'd96);
      in_valid = 1'b0; start4 = 1'b1; tick(); start4 = 1'b0;
      checks++; if (cnt4 !== 17'd1 || rdy4 !== 1'b1) begin errors++; $display("FAIL run_start_ignored: got cnt=%0d rdy=%b expected 1 1", cnt4, rdy4); end
      feed(8'd7, 8'd8, 16'd60);
      feed(8'd3, 8'd5, 16'd15);
      in_valid = 1'b0;
      n = 0;
      while (done4 !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (cnt4 !== 17'd4 || err4 !== 17'd3) begin errors++; $display("FAIL ctl_counts: got cnt=%0d err=%0d expected 4 3", cnt4, err4); end
      checks++; if (sum4 !== 32'd12 || max4 !== 16'd4) begin errors++; $display("FAIL ctl_ed: got sum=%0d max=%0d expected 12 4", sum4, max4); end

      start4 = 1'b1; tick(); start4 = 1'b0;
      feed(8'd10, 8'd10, 16'd96);
      feed(8'd200, 8'd200, 16'd0);
      in_valid = 1'b0;
      tick(); tick();
      checks++; if (cnt4 !== 17'd2 || max4 !== 16'd40000) begin errors++; $display("FAIL midrun_metrics: got cnt=%0d max=%0d expected 2 40000", cnt4, max4); end
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      checks++; if ({rdy4, busy4, done4} !== 3'b000 || cnt4 !== 17'd0) begin errors++; $display("FAIL midrun_reset_ctrl: got ctrl=%b cnt=%0d expected 000 0", {rdy4, busy4, done4}, cnt4); end
      checks++; if (sum4 !== 32'd0 || max4 !== 16'd0 || err4 !== 17'd0) begin errors++; $display("FAIL midrun_reset_ed: got sum=%0d max=%0d err=%0d expected 0", sum4, max4, err4); end
      tick();
      start4 = 1'b1; tick(); start4 = 1'b0;
      feed(8'd3, 8'd5, 16'd15);
      feed(8'd255, 8'd255, 16'd65025);
      feed(8'd0, 8'd9, 16'd0);
      feed(8'd16, 8'd16, 16'd256);
      in_valid = 1'b0;
      n = 0;
      while (done4 !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (done4 !== 1'b1 || cnt4 !== 17'd4 || err4 !== 17'd0) begin errors++; $display("FAIL post_reset_run: got done=%b cnt=%0d err=%0d expected 1 4 0", done4, cnt4, err4); end
   endtask

   initial begin
      test_reset();
      test_exact();
      test_error();
      test_throttle();
      test_saturation();
      test_control();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
